// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Borrows the shared execute-stage ALU for one add (multiply) or one
// subtract (divide) per cycle while busy=1. Multiply is shift-add over
// {hi,lo}; divide is restoring with r in hi and q in lo.
// Optional feature macro: MD_SIGNED_EN (signed ops via absolute values at
// accept and a one-cycle FIX state that applies the sign afterwards).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. req_ready is 1 only in IDLE. Once resp_valid rises, it and
// resp_data stay stable until the edge where resp_ready is sampled 1.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic [3:0]      alu_func,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_lt_u
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    // State is kept in a named register so checkers can bind to it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic [XLEN-1:0] acc_hi;   // multiply: high product half; divide: remainder
    logic [XLEN-1:0] acc_lo;   // multiply: multiplier / low half; divide: quotient
    logic [XLEN-1:0] opnd_b;   // multiplicand or divisor

    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;
    logic [XLEN-1:0] r_sh;
    logic            r_carry;
    logic            div_take;
    logic [XLEN-1:0] mul_sum;
    logic            mul_carry;
    logic [XLEN-1:0] result_sel;

`ifdef MD_SIGNED_EN
    logic            fix_hi;   // negate product (mul) or remainder (div)
    logic            fix_lo;   // negate quotient (div only)
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic            nxt_fix_hi;
    logic            nxt_fix_lo;

    // Operand conditioning at accept: magnitudes in, sign decisions remembered.
    always_comb begin
        a_signed   = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
        b_signed   = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
        a_neg      = a_signed && req_a[XLEN-1];
        b_neg      = b_signed && req_b[XLEN-1];
        a_in       = a_neg ? -req_a : req_a;
        b_in       = b_neg ? -req_b : req_b;
        if (req_op[2]) begin
            // Quotient sign is only applied when the divisor is nonzero so that
            // divide-by-zero still yields all ones.
            nxt_fix_lo = (a_neg ^ b_neg) && (req_b != '0);
            nxt_fix_hi = a_neg;
        end else begin
            nxt_fix_lo = a_neg ^ b_neg;
            nxt_fix_hi = a_neg ^ b_neg;
        end
    end
`else
    // Unsigned-only build: operands are used as presented.
    always_comb begin
        a_in = req_a;
        b_in = req_b;
    end
`endif

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // ALU operand steering; the ALU is only driven with real work in RUN.
    always_comb begin
        r_sh     = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
        r_carry  = acc_hi[XLEN-1];
        alu_func = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        if (state == S_RUN) begin
            if (op[2]) begin
                alu_func = ALU_SUB;
                alu_a    = r_sh;
                alu_b    = opnd_b;
            end else begin
                alu_func = ALU_ADD;
                alu_a    = acc_hi;
                alu_b    = opnd_b;
            end
        end
    end

    // Per-iteration datapath decisions derived from the ALU result.
    always_comb begin
        // The 33rd bit shifted out of r means r_sh already exceeds any divisor.
        div_take   = r_carry || !alu_lt_u;
        mul_sum    = acc_lo[0] ? alu_out : acc_hi;
        // Carry out of hi + multiplicand detected as a wrapped (smaller) sum.
        mul_carry  = acc_lo[0] && (alu_out < acc_hi);
        result_sel = ((op == 3'd0) || (op[2:1] == 2'b10)) ? acc_lo : acc_hi;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            op         <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd_b     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
`ifdef MD_SIGNED_EN
            fix_hi     <= 1'b0;
            fix_lo     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op     <= req_op;
                        acc_hi <= '0;
                        acc_lo <= a_in;
                        opnd_b <= b_in;
                        count  <= '0;
`ifdef MD_SIGNED_EN
                        fix_hi <= nxt_fix_hi;
                        fix_lo <= nxt_fix_lo;
`endif
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (op[2]) begin
                        if (div_take) begin
                            acc_hi <= alu_out;
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= r_sh;
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= {mul_carry, mul_sum[XLEN-1:1]};
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    count <= count + CW'(1);
                    if (count == LAST_ITER) begin
`ifdef MD_SIGNED_EN
                        state <= S_FIX;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef MD_SIGNED_EN
                S_FIX: begin
                    if (op[2]) begin
                        if (fix_lo) acc_lo <= -acc_lo;
                        if (fix_hi) acc_hi <= -acc_hi;
                    end else if (fix_hi) begin
                        {acc_hi, acc_lo} <= -{acc_hi, acc_lo};
                    end
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    // First DONE cycle registers the selected result; the
                    // response is then held until the consumer takes it.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= result_sel;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Provides a behavioural
// ALU, directed cases, random cases against an arithmetic reference model,
// back-pressure, mid-operation reset and back-to-back traffic.
module tb_muldiv_seq;

`ifdef MD_SIGNED_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic [3:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_lt_u;

    int vectors;
    int miscompares;

    muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_func   (alu_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_lt_u   (alu_lt_u)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model
    assign alu_out  = (alu_func == 4'd0) ? (alu_a + alu_b) : (alu_a - alu_b);
    assign alu_lt_u = (alu_a < alu_b);

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: RV32M results from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        logic [31:0] q;
        logic [31:0] r;
        p = {32'b0, a} * {32'b0, b};
        if (op == 3'd0) return p[31:0];
        if (op == 3'd3) return p[63:32];
        if (op == 3'd1 || op == 3'd2) begin
`ifdef MD_SIGNED_EN
            sa = longint'($signed(a));
            sb = (op == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
            p  = sa * sb;
`endif
            return p[63:32];
        end
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
`ifdef MD_SIGNED_EN
            if (op == 3'd4 || op == 3'd6) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    ia = int'(a);
                    ib = int'(b);
                    q  = ia / ib;
                    r  = ia % ib;
                end
            end
`endif
        end
        return op[1] ? r : q;
    endfunction

    function automatic logic [31:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Driver: issue one request, check latency, busy, ALU function and result.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input string name);
        int   t;
        int   lat;
        bit   busy_ok;
        logic [3:0] exp_func;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready before issue: got %b required 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 3'($urandom_range(0, 7));
        exp_func  = op[2] ? 4'd1 : 4'd0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (resp_valid !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                vectors++;
                if (alu_func !== exp_func) begin
                    miscompares++;
                    $display("FAIL %s alu_func: got %0d required %0d", name, alu_func, exp_func);
                end
            end
        end
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, LAT);
        end
        vectors++;
        if (!busy_ok || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy during op: got low required 1", name);
        end
        vectors++;
        if (resp_data !== exp_data) begin
            miscompares++;
            $display("FAIL %s resp_data: got %h required %h (op %0d a %h b %h)",
                     name, resp_data, exp_data, op, a, b);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s return to idle: got valid=%b ready=%b busy=%b required 0 1 0",
                     name, resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset flags: got ready=%b valid=%b busy=%b required 1 0 0",
                     req_ready, resp_valid, busy);
        end
        vectors++;
        if (resp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset resp_data: got %h required 00000000", resp_data);
        end
        vectors++;
        if (alu_func !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            miscompares++;
            $display("FAIL reset alu outputs: got %0d %h %h required 0 0 0", alu_func, alu_a, alu_b);
        end
    endtask

    task automatic test_directed();
        do_op(3'd0, 32'd7, 32'd6, 32'd42, "mul_7x6");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
        do_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
        do_op(3'd7, 32'h1234, 32'd0, 32'h1234, "remu_by_zero");
        do_op(3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, "divu_carry");
        do_op(3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, "remu_carry");
`ifdef MD_SIGNED_EN
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
        do_op(3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div_m5_0");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "mulh_m1_m1");
`else
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulh_as_mulhu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, "div_as_divu");
`endif
    endtask

    task automatic test_backpressure();
        int   t;
        logic ok_valid;
        logic ok_data;
        logic ok_ready;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd7;
        req_b     = 32'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (resp_valid !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        ok_valid = 1'b1;
        ok_data  = 1'b1;
        ok_ready = 1'b1;
        // A competing request during DONE must be ignored.
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_a     = 32'd9;
        req_b     = 32'd9;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1) ok_valid = 1'b0;
            if (resp_data !== 32'd42) ok_data = 1'b0;
            if (req_ready !== 1'b0) ok_ready = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        vectors++;
        if (!ok_valid) begin
            miscompares++;
            $display("FAIL hold resp_valid: got dropped required held 1");
        end
        vectors++;
        if (!ok_data || resp_data !== 32'd42) begin
            miscompares++;
            $display("FAIL hold resp_data: got %h required 0000002a", resp_data);
        end
        vectors++;
        if (!ok_ready) begin
            miscompares++;
            $display("FAIL hold req_ready: got 1 required 0");
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold release: got ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = $urandom;
        req_b     = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid reset: got ready=%b valid=%b busy=%b required 1 0 0",
                     req_ready, resp_valid, busy);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL mid reset response: got resp_valid=1 required none");
        end
        do_op(3'd0, 32'd3, 32'd5, 32'd15, "mul_after_reset");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, ref_result(op, a, b), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 1000));
            do_op(3'(i), a, b, ref_result(3'(i), a, b), "back_to_back");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
